// File: rtl/nlms_weight_update_if.sv
// rtl/nlms_weight_update_if.sv - handshake and data bundle between the filter pass and the weight update stage
// Purpose: groups the operands the filter pass hands over and the weights and status returned to it.
// Signals:
//   start      one-cycle pulse; e, n and reff are valid in this cycle
//   clear      synchronous weight clear and abort
//   e          signed error sample
//   n          unsigned reference energy
//   reff[0:31] signed reference taps, reff[0] newest
//   weight_out signed Q5.10 weights, registered
//   busy, done status from the update stage
// Modports: master drives operands (filter side), slave is the update stage.
interface nlms_weight_update_if;
    logic               start;
    logic               clear;
    logic signed [13:0] e;
    logic        [31:0] n;
    logic signed [13:0] reff       [32];
    logic signed [15:0] weight_out [32];
    logic               busy;
    logic               done;

    modport master (
        output start, clear, e, n, reff,
        input  weight_out, busy, done
    );

    modport slave (
        input  start, clear, e, n, reff,
        output weight_out, busy, done
    );
endinterface

// File: rtl/nlms_weight_update.sv
// rtl/nlms_weight_update.sv - NLMS weight update for the 32-tap adaptive FIR, one tap per clock
// Purpose: latches e, n and the reference taps on start, normalises by floor(log2(n)),
//          then walks the 32 taps through one shared multiplier updating each Q5.10 weight
//          with saturation.
// Ports:
//   clk   system clock
//   rstn  synchronous active-low reset
//   bus   nlms_weight_update_if.slave: start/clear/e/n/reff in, weight_out/busy/done out
module nlms_weight_update #(
    parameter int TAPS     = 32,
    parameter int MU_SHIFT = 4
) (
    input  logic                 clk,
    input  logic                 rstn,
    nlms_weight_update_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, NORM, UPDATE, DONE} state_t;

    state_t             state;
    state_t             state_next;
    logic               latch_en;
    logic               norm_en;
    logic               upd_en;
    logic               busy_c;
    logic               done_c;

    logic signed [13:0] e_lat;
    logic        [31:0] n_lat;
    logic signed [13:0] x_lat [TAPS];
    logic signed [15:0] w     [TAPS];
    logic        [4:0]  k;
    logic        [5:0]  sh;
    logic        [4:0]  msb;

    logic signed [27:0] p;
    logic signed [47:0] q;
    logic signed [47:0] delta;
    logic signed [47:0] sum;
    logic signed [15:0] w_new;

    // clear aborts from any state, so it sits alongside reset on the state register
    always_ff @(posedge clk) begin
        if (!rstn || bus.clear) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        latch_en   = 1'b0;
        norm_en    = 1'b0;
        upd_en     = 1'b0;
        busy_c     = 1'b1;
        done_c     = 1'b0;
        case (state)
            IDLE: begin
                busy_c = 1'b0;
                if (bus.start) begin
                    latch_en   = 1'b1;
                    state_next = NORM;
                end
            end
            NORM: begin
                norm_en    = 1'b1;
                state_next = UPDATE;
            end
            UPDATE: begin
                upd_en = 1'b1;
                if (k == 5'(TAPS - 1)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done_c     = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Index of the highest set bit; n==0 falls out as 0, same as n==1
    always_comb begin
        msb = '0;
        for (int i = 0; i < 32; i++) begin
            if (n_lat[i]) begin
                msb = 5'(i);
            end
        end
    end

    // Shared multiplier path: Q5.10 alignment by <<10, then >>> floors toward minus infinity
    assign p     = 28'(e_lat) * 28'(x_lat[k]);
    assign q     = 48'(p) <<< 10;
    assign delta = q >>> sh;
    assign sum   = 48'(w[k]) + delta;

    always_comb begin
        if (sum > 48'sd32767) begin
            w_new = 16'sh7fff;
        end else if (sum < -48'sd32768) begin
            w_new = 16'sh8000;
        end else begin
            w_new = sum[15:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            e_lat <= '0;
            n_lat <= '0;
            k     <= '0;
            sh    <= '0;
            for (int i = 0; i < TAPS; i++) begin
                x_lat[i] <= '0;
                w[i]     <= '0;
            end
        end else if (bus.clear) begin
            k <= '0;
            for (int i = 0; i < TAPS; i++) begin
                w[i] <= '0;
            end
        end else begin
            if (latch_en) begin
                e_lat <= bus.e;
                n_lat <= bus.n;
                for (int i = 0; i < TAPS; i++) begin
                    x_lat[i] <= bus.reff[i];
                end
            end
            if (norm_en) begin
                sh <= 6'(msb) + 6'(MU_SHIFT);
                k  <= '0;
            end
            if (upd_en) begin
                w[k] <= w_new;
                k    <= k + 5'd1;
            end
        end
    end

    assign bus.busy = busy_c;
    assign bus.done = done_c;

    for (genvar g = 0; g < TAPS; g++) begin : g_wout
        assign bus.weight_out[g] = w[g];
    end
endmodule
